dispatch_scheduler: RTL and testbench

Issue-stage controller between the register-file read stage and the execution units (ALU, BRU, SYS). Keeps a 32-entry register scoreboard and an outstanding-instruction counter. Holds each decoded instruction until its source and destination registers are free and its target unit is ready, then emits a one-cycle dispatch grant to exactly one unit. SYSTEM instructions are serialized: the pipeline drains before one issues, and nothing issues until it writes back.

---
 rtl/dispatch_scheduler.sv | 131 +++++++++++++
 tb/tb_dispatch_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_scheduler.sv
// Issue-stage controller: register scoreboard, in-flight counter and SYS-op
// serialization in front of the ALU/BRU/SYS execution units.
module dispatch_scheduler #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [4:0]       in_rd,
  input  logic [1:0]       in_unit,
  input  logic             alu_ready,
  input  logic             bru_ready,
  input  logic             sys_ready,
  output logic             alu_valid,
  output logic             bru_valid,
  output logic             sys_valid,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             wb_sys,
  input  logic             invalidate,
  output logic [31:0]      busy,
  output logic [CNT_W-1:0] outstanding,
  output logic [31:0]      hazard_stalls
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    SYS_WAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      busy_q, busy_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [31:0]      hazard_stalls_q, hazard_stalls_d;

  logic hazard, full, unit_rdy, is_sys, base_go, go, stall_inc;

  // No writeback bypass: a consumer waits for the registered clear.
  assign hazard  = busy_q[in_rs1] | busy_q[in_rs2] | busy_q[in_rd];
  assign full    = (outstanding_q == CNT_W'(MAX_OUTSTANDING));
  assign is_sys  = (in_unit == 2'd2);
  assign base_go = in_valid & ~invalidate & ~hazard & ~full & unit_rdy;

  always_comb begin
    unit_rdy = 1'b0;
    case (in_unit)
      2'd0:    unit_rdy = alu_ready;
      2'd1:    unit_rdy = bru_ready;
      2'd2:    unit_rdy = sys_ready;
      default: unit_rdy = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    case (state_q)
      RUN: begin
        go = base_go & ~is_sys;
        if (in_valid && is_sys && !invalidate) state_d = DRAIN;
      end
      DRAIN: begin
        go = base_go & is_sys & (outstanding_q == '0);
        if (invalidate)  state_d = RUN;
        else if (go)     state_d = SYS_WAIT;
      end
      SYS_WAIT: begin
        if (wb_valid && wb_sys) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign in_ready  = go;
  assign alu_valid = go & (in_unit == 2'd0);
  assign bru_valid = go & (in_unit == 2'd1);
  assign sys_valid = go & (in_unit == 2'd2);

  // Per-bit scoreboard update; set dominates clear, x0 is never tracked.
  assign busy_d[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
      assign busy_d[gi] = (go && in_rd == 5'(gi)) ||
                          (busy_q[gi] && !(wb_valid && wb_rd == 5'(gi)));
    end
  endgenerate

  always_comb begin
    outstanding_d = outstanding_q;
    if (go && !wb_valid)
      outstanding_d = outstanding_q + CNT_W'(1);
    else if (!go && wb_valid && outstanding_q != '0)
      outstanding_d = outstanding_q - CNT_W'(1);
  end

  assign stall_inc = in_valid & hazard & (state_q != SYS_WAIT);

  always_comb begin
    hazard_stalls_d = hazard_stalls_q;
    if (stall_inc && hazard_stalls_q != 32'hFFFF_FFFF)
      hazard_stalls_d = hazard_stalls_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= RUN;
      busy_q          <= '0;
      outstanding_q   <= '0;
      hazard_stalls_q <= '0;
    end else begin
      state_q         <= state_d;
      busy_q          <= busy_d;
      outstanding_q   <= outstanding_d;
      hazard_stalls_q <= hazard_stalls_d;
    end
  end

  assign busy          = busy_q;
  assign outstanding   = outstanding_q;
  assign hazard_stalls = hazard_stalls_q;

  // A writeback with nothing in flight is an upstream protocol violation.
  a_wb_underflow: assert property (@(posedge clk) disable iff (rst)
    wb_valid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Directed bench for dispatch_scheduler: default instance plus a
// MAX_OUTSTANDING=2 instance for the full-pipeline case.
module tb_dispatch_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [1:0]  in_unit;
  logic        alu_ready, bru_ready, sys_ready;
  logic        alu_valid, bru_valid, sys_valid;
  logic        wb_valid, wb_sys, invalidate;
  logic [4:0]  wb_rd;
  logic [31:0] busy, hazard_stalls;
  logic [3:0]  outstanding;

  logic        b_in_valid, b_in_ready, b_wb_valid;
  logic [4:0]  b_in_rd, b_wb_rd;
  logic        b_alu_valid, b_bru_valid, b_sys_valid;
  logic [31:0] b_busy, b_hazard_stalls;
  logic [1:0]  b_outstanding;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dispatch_scheduler dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_unit(in_unit),
    .alu_ready(alu_ready), .bru_ready(bru_ready), .sys_ready(sys_ready),
    .alu_valid(alu_valid), .bru_valid(bru_valid), .sys_valid(sys_valid),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_sys(wb_sys),
    .invalidate(invalidate),
    .busy(busy), .outstanding(outstanding), .hazard_stalls(hazard_stalls)
  );

  dispatch_scheduler #(.MAX_OUTSTANDING(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_rs1(5'd0), .in_rs2(5'd0), .in_rd(b_in_rd), .in_unit(2'd0),
    .alu_ready(1'b1), .bru_ready(1'b1), .sys_ready(1'b1),
    .alu_valid(b_alu_valid), .bru_valid(b_bru_valid), .sys_valid(b_sys_valid),
    .wb_valid(b_wb_valid), .wb_rd(b_wb_rd), .wb_sys(1'b0),
    .invalidate(1'b0),
    .busy(b_busy), .outstanding(b_outstanding), .hazard_stalls(b_hazard_stalls)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0; in_unit = 2'd0;
    alu_ready = 1'b1; bru_ready = 1'b1; sys_ready = 1'b1;
    wb_valid = 1'b0; wb_rd = 5'd0; wb_sys = 1'b0; invalidate = 1'b0;
  endtask

  task automatic b_idle();
    b_in_valid = 1'b0; b_in_rd = 5'd0; b_wb_valid = 1'b0; b_wb_rd = 5'd0;
  endtask

  task automatic op(input logic [4:0] rs1, input logic [4:0] rs2,
                    input logic [4:0] rd, input logic [1:0] unit);
    in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_unit = unit;
  endtask

  task automatic do_wb(input logic [4:0] rd, input logic sys);
    wb_valid = 1'b1; wb_rd = rd; wb_sys = sys;
  endtask

  initial begin
    // reset
    rst = 1'b1; idle(); b_idle();
    step(); step();
    rst = 1'b0; #1;
    check("rst_busy", busy, 32'h0);
    check("rst_outstanding", 32'(outstanding), 32'd0);
    check("rst_stalls", hazard_stalls, 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_valids", 32'({alu_valid, bru_valid, sys_valid}), 32'd0);
    check("rst_b_outstanding", 32'(b_outstanding), 32'd0);

    // independent stream
    for (int i = 1; i <= 4; i++) begin
      idle(); op(5'd0, 5'd0, 5'(i), 2'd0); #1;
      check("t1_ready", 32'(in_ready), 32'd1);
      check("t1_valids", 32'({alu_valid, bru_valid, sys_valid}), 32'b100);
      step();
    end
    idle(); #1;
    check("t1_busy", busy, 32'h1E);
    check("t1_outstanding", 32'(outstanding), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      idle(); do_wb(5'(i), 1'b0); step();
    end
    idle(); #1;
    check("t1_busy_clear", busy, 32'h0);
    check("t1_out_clear", 32'(outstanding), 32'd0);

    // RAW hazard
    idle(); op(5'd0, 5'd0, 5'd5, 2'd0); #1;
    check("t2_producer", 32'(in_ready), 32'd1); step();
    idle(); op(5'd5, 5'd0, 5'd6, 2'd0); #1;
    check("t2_stall_a", 32'(in_ready), 32'd0); step();
    idle(); op(5'd5, 5'd0, 5'd6, 2'd0); do_wb(5'd5, 1'b0); #1;
    check("t2_stall_wb", 32'(in_ready), 32'd0); step();
    idle(); op(5'd5, 5'd0, 5'd6, 2'd0); #1;
    check("t2_grant", 32'(in_ready), 32'd1); step();
    idle(); #1;
    check("t2_stalls", hazard_stalls, 32'd2);
    check("t2_busy", busy, 32'h40);
    check("t2_outstanding", 32'(outstanding), 32'd1);
    idle(); do_wb(5'd6, 1'b0); step();

    // full pipeline on the depth-2 instance
    idle(); b_idle();
    b_in_valid = 1'b1; b_in_rd = 5'd1; #1;
    check("t3_first", 32'(b_in_ready), 32'd1); step();
    b_in_rd = 5'd2; #1;
    check("t3_second", 32'(b_in_ready), 32'd1); step();
    b_in_rd = 5'd3; #1;
    check("t3_full_stall", 32'(b_in_ready), 32'd0);
    check("t3_full_count", 32'(b_outstanding), 32'd2); step();
    b_wb_valid = 1'b1; b_wb_rd = 5'd1; #1;
    check("t3_full_with_wb", 32'(b_in_ready), 32'd0); step();
    b_wb_rd = 5'd2; #1;
    check("t3_dispatch_wb", 32'(b_in_ready), 32'd1); step();
    b_in_valid = 1'b0; b_wb_rd = 5'd3; #1;
    check("t3_count_held", 32'(b_outstanding), 32'd1);
    check("t3_busy", b_busy, 32'h8); step();
    b_idle(); #1;
    check("t3_drained", 32'(b_outstanding), 32'd0);

    // SYS serialization
    idle(); op(5'd0, 5'd0, 5'd1, 2'd0); step();
    idle(); op(5'd0, 5'd0, 5'd2, 2'd0); step();
    idle(); op(5'd0, 5'd0, 5'd0, 2'd2); #1;
    check("t4_sys_in_run", 32'({in_ready, sys_valid}), 32'd0); step();
    idle(); op(5'd0, 5'd0, 5'd0, 2'd2); do_wb(5'd1, 1'b0); #1;
    check("t4_drain_out2", 32'(sys_valid), 32'd0); step();
    idle(); op(5'd0, 5'd0, 5'd0, 2'd2); do_wb(5'd2, 1'b0); #1;
    check("t4_drain_out1", 32'(sys_valid), 32'd0); step();
    idle(); op(5'd0, 5'd0, 5'd0, 2'd2); #1;
    check("t4_sys_grant", 32'({in_ready, alu_valid, bru_valid, sys_valid}), 32'b1001); step();
    idle(); op(5'd0, 5'd0, 5'd7, 2'd0); #1;
    check("t4_wait_block", 32'(in_ready), 32'd0);
    check("t4_wait_count", 32'(outstanding), 32'd1); step();
    idle(); op(5'd0, 5'd0, 5'd7, 2'd0); do_wb(5'd0, 1'b1); #1;
    check("t4_wb_sys_cycle", 32'(in_ready), 32'd0); step();
    idle(); op(5'd0, 5'd0, 5'd7, 2'd0); #1;
    check("t4_after_sys", 32'({alu_valid, bru_valid, sys_valid}), 32'b100); step();
    idle(); do_wb(5'd7, 1'b0); step();

    // invalidate
    idle(); op(5'd0, 5'd0, 5'd8, 2'd0); invalidate = 1'b1; #1;
    check("t5_inv_run", 32'(in_ready), 32'd0); step();
    idle(); op(5'd0, 5'd0, 5'd0, 2'd2); #1;
    check("t5_sys_enter", 32'(in_ready), 32'd0); step();
    idle(); op(5'd0, 5'd0, 5'd0, 2'd2); invalidate = 1'b1; #1;
    check("t5_inv_drain", 32'({in_ready, sys_valid}), 32'd0); step();
    idle(); op(5'd0, 5'd0, 5'd8, 2'd0); #1;
    check("t5_back_to_run", 32'(in_ready), 32'd1); step();
    idle(); do_wb(5'd8, 1'b0); step();
    idle(); op(5'd0, 5'd0, 5'd0, 2'd2); step();
    idle(); op(5'd0, 5'd0, 5'd0, 2'd2); #1;
    check("t5_sys_grant", 32'(sys_valid), 32'd1); step();
    idle(); op(5'd0, 5'd0, 5'd9, 2'd0); invalidate = 1'b1; #1;
    check("t5_inv_wait", 32'(in_ready), 32'd0); step();
    idle(); op(5'd0, 5'd0, 5'd9, 2'd0); #1;
    check("t5_still_wait", 32'(in_ready), 32'd0); step();
    idle(); op(5'd0, 5'd0, 5'd9, 2'd0); do_wb(5'd0, 1'b1); step();
    idle(); op(5'd0, 5'd0, 5'd9, 2'd0); #1;
    check("t5_resume", 32'(in_ready), 32'd1); step();
    idle(); do_wb(5'd9, 1'b0); step();

    // x0, unit selection, illegal unit
    idle(); op(5'd0, 5'd0, 5'd0, 2'd0); #1;
    check("t6_rd0_grant", 32'(in_ready), 32'd1); step();
    idle(); #1;
    check("t6_rd0_busy", busy, 32'h0);
    check("t6_rd0_count", 32'(outstanding), 32'd1);
    idle(); op(5'd0, 5'd0, 5'd9, 2'd0); step();
    idle(); op(5'd0, 5'd0, 5'd10, 2'd0); #1;
    check("t6_rs0_nostall", 32'(in_ready), 32'd1); step();
    idle(); op(5'd0, 5'd0, 5'd11, 2'd1); bru_ready = 1'b0; #1;
    check("t6_bru_notready", 32'(in_ready), 32'd0); step();
    idle(); op(5'd0, 5'd0, 5'd11, 2'd1); #1;
    check("t6_bru_grant", 32'({alu_valid, bru_valid, sys_valid}), 32'b010); step();
    idle(); op(5'd0, 5'd0, 5'd0, 2'd3); #1;
    check("t6_illegal", 32'({in_ready, alu_valid, bru_valid, sys_valid}), 32'd0); step();
    idle(); #1;
    check("t6_busy", busy, 32'hE00);
    check("t6_count", 32'(outstanding), 32'd4);
    check("t6_stalls", hazard_stalls, 32'd2);
    idle(); do_wb(5'd0, 1'b0); step();
    idle(); do_wb(5'd9, 1'b0); step();
    idle(); do_wb(5'd10, 1'b0); step();
    idle(); do_wb(5'd11, 1'b0); step();
    idle(); #1;
    check("t6_drained", 32'(outstanding), 32'd0);

    // reset mid-operation
    idle(); op(5'd0, 5'd0, 5'd12, 2'd0); step();
    idle(); op(5'd12, 5'd0, 5'd13, 2'd0); step();
    idle(); #1;
    check("t7_pre_stalls", hazard_stalls, 32'd3);
    rst = 1'b1; step();
    rst = 1'b0; #1;
    check("t7_busy", busy, 32'h0);
    check("t7_count", 32'(outstanding), 32'd0);
    check("t7_stalls", hazard_stalls, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
